cgra_cfg_sequencer: RTL and testbench

Command-driven controller that owns the CGRA Interconnect configuration port (config_addr/config_data/config_read/config_write) and the per-column stall vector. A host-side bridge pushes commands one at a time over a valid/ready handshake. Supported commands cover bitstream writes, readback, readback-with-compare, stall control, flush pulses and timed waits. It replaces hand-sequenced bench/firmware timing with one fixed, cycle-exact sequencer placed between the host bridge and the Interconnect top.

---
 rtl/cgra_cfg_sequencer_pkg.sv | 27 ++
 rtl/cgra_cfg_sequencer_if.sv | 25 ++
 rtl/cgra_cfg_sequencer_timer.sv | 34 +++
 rtl/cgra_cfg_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_cgra_cfg_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cgra_cfg_sequencer_pkg.sv
// Shared types for the CGRA configuration sequencer: opcodes, FSM states, bus widths.
package cgra_cfg_seq_pkg;

  localparam int CFG_ADDR_W = 32;
  localparam int CFG_DATA_W = 32;

  typedef enum logic [2:0] {
    OP_WRITE  = 3'd0,
    OP_READ   = 3'd1,
    OP_VERIFY = 3'd2,
    OP_STALL  = 3'd3,
    OP_PULSE  = 3'd4,
    OP_WAIT   = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RESP,
    ST_PHI,
    ST_PGAP,
    ST_PLO,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/cgra_cfg_sequencer_if.sv
// Host-side command/response handshake of the configuration sequencer.
interface cgra_cfg_sequencer_if;
  import cgra_cfg_seq_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [CFG_ADDR_W-1:0] cmd_addr;
  logic [CFG_DATA_W-1:0] cmd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [CFG_DATA_W-1:0] rsp_data;
  logic                  rsp_mismatch;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_mismatch
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_mismatch
  );

endinterface

// File: rtl/cgra_cfg_sequencer_timer.sv
// Loadable down-counter with zero flag; times the WR, RD, PHI and WAIT windows.
module cfg_seq_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cgra_cfg_sequencer.sv
// Cycle-exact command sequencer driving the CGRA configuration port and stall vector.
// Optional first-mismatch capture is enabled by defining CFG_SEQ_ERR_LOG_EN.
module cgra_cfg_sequencer
  import cgra_cfg_seq_pkg::*;
#(
  parameter int                  NUM_COLS     = 4,
  parameter int                  RD_LAT       = 5,
  parameter int                  WR_CYCLES    = 1,
  parameter int                  PULSE_CYCLES = 2,
  parameter logic [NUM_COLS-1:0] STALL_RST    = '1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cgra_cfg_sequencer_if.slave   cmd_if,
  output logic [CFG_ADDR_W-1:0] config_addr,
  output logic [CFG_DATA_W-1:0] config_data,
  output logic                  config_read,
  output logic                  config_write,
  input  logic [CFG_DATA_W-1:0] read_config_data,
  output logic [NUM_COLS-1:0]   stall,
  output logic                  busy,
  output logic [15:0]           err_cnt,
  output logic [CFG_ADDR_W-1:0] first_err_addr,
  output logic [CFG_DATA_W-1:0] first_err_data
);

  state_e                state_q, state_d;
  logic [CFG_ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
  logic [CFG_DATA_W-1:0] cfg_data_q, cfg_data_d;
  logic [NUM_COLS-1:0]   stall_q, stall_d;
  logic [CFG_DATA_W-1:0] cmp_data_q, cmp_data_d;
  logic                  verify_q, verify_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [CFG_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_mis_q, rsp_mis_d;
  logic [15:0]           err_cnt_q, err_cnt_d;

  logic        tmr_load, tmr_dec, tmr_zero;
  logic [31:0] tmr_load_val;
  logic        cmd_accept, sample_now, sample_mis;

  cfg_seq_timer #(.W(32)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign cmd_if.cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q;
  assign cmd_accept       = cmd_if.cmd_valid && cmd_if.cmd_ready;
  // read_config_data is sampled on the edge that closes the last RD cycle.
  assign sample_now       = (state_q == ST_RD) && tmr_zero;
  assign sample_mis       = verify_q && (read_config_data != cmp_data_q);

  always_comb begin
    state_d      = state_q;
    cfg_addr_d   = cfg_addr_q;
    cfg_data_d   = cfg_data_q;
    stall_d      = stall_q;
    cmp_data_d   = cmp_data_q;
    verify_d     = verify_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_mis_d    = rsp_mis_q;
    err_cnt_d    = err_cnt_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          case (op_e'(cmd_if.cmd_op))
            OP_WRITE: begin
              cfg_addr_d   = cmd_if.cmd_addr;
              cfg_data_d   = cmd_if.cmd_data;
              tmr_load     = 1'b1;
              tmr_load_val = 32'(WR_CYCLES - 1);
              state_d      = ST_WR;
            end
            OP_READ, OP_VERIFY: begin
              cfg_addr_d   = cmd_if.cmd_addr;
              cmp_data_d   = cmd_if.cmd_data;
              verify_d     = (op_e'(cmd_if.cmd_op) == OP_VERIFY);
              tmr_load     = 1'b1;
              tmr_load_val = 32'(RD_LAT - 1);
              state_d      = ST_RD;
            end
            OP_STALL: stall_d = cmd_if.cmd_data[NUM_COLS-1:0];
            OP_PULSE: begin
              cfg_addr_d   = cmd_if.cmd_addr;
              cfg_data_d   = cmd_if.cmd_data;
              tmr_load     = 1'b1;
              tmr_load_val = 32'(PULSE_CYCLES - 1);
              state_d      = ST_PHI;
            end
            OP_WAIT: begin
              // A zero count is finished in the accept cycle itself.
              if (cmd_if.cmd_data != '0) begin
                tmr_load     = 1'b1;
                tmr_load_val = cmd_if.cmd_data - 32'd1;
                state_d      = ST_WAIT;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WR: begin
        if (tmr_zero) state_d = ST_IDLE;
        else          tmr_dec = 1'b1;
      end
      ST_RD: begin
        if (tmr_zero) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = read_config_data;
          rsp_mis_d   = sample_mis;
          if (sample_mis && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
          state_d     = ST_RESP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (cmd_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_PHI: begin
        if (tmr_zero) state_d = ST_PGAP;
        else          tmr_dec = 1'b1;
      end
      ST_PGAP: begin
        cfg_data_d = '0;
        state_d    = ST_PLO;
      end
      ST_PLO:  state_d = ST_IDLE;
      ST_WAIT: begin
        if (tmr_zero) state_d = ST_IDLE;
        else          tmr_dec = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      stall_q     <= STALL_RST;
      cmp_data_q  <= '0;
      verify_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_mis_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      stall_q     <= stall_d;
      cmp_data_q  <= cmp_data_d;
      verify_q    <= verify_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mis_q   <= rsp_mis_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign config_addr         = cfg_addr_q;
  assign config_data         = cfg_data_q;
  assign config_write        = (state_q == ST_WR) || (state_q == ST_PHI) || (state_q == ST_PLO);
  assign config_read         = (state_q == ST_RD);
  assign stall               = stall_q;
  assign busy                = (state_q != ST_IDLE) || rsp_valid_q;
  assign err_cnt             = err_cnt_q;
  assign cmd_if.rsp_valid    = rsp_valid_q;
  assign cmd_if.rsp_data     = rsp_data_q;
  assign cmd_if.rsp_mismatch = rsp_mis_q;

`ifdef CFG_SEQ_ERR_LOG_EN
  logic                  err_logged_q, err_logged_d;
  logic [CFG_ADDR_W-1:0] fe_addr_q, fe_addr_d;
  logic [CFG_DATA_W-1:0] fe_data_q, fe_data_d;

  always_comb begin
    err_logged_d = err_logged_q;
    fe_addr_d    = fe_addr_q;
    fe_data_d    = fe_data_q;
    if (sample_now && sample_mis && !err_logged_q) begin
      err_logged_d = 1'b1;
      fe_addr_d    = cfg_addr_q;
      fe_data_d    = read_config_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_logged_q <= 1'b0;
      fe_addr_q    <= '0;
      fe_data_q    <= '0;
    end else begin
      err_logged_q <= err_logged_d;
      fe_addr_q    <= fe_addr_d;
      fe_data_q    <= fe_data_d;
    end
  end

  assign first_err_addr = fe_addr_q;
  assign first_err_data = fe_data_q;
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

endmodule

// File: tb/tb_cgra_cfg_sequencer.sv
// Self-checking bench for cgra_cfg_sequencer: timeline reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_cgra_cfg_sequencer;

  localparam int NUM_COLS     = 4;
  localparam int RD_LAT       = 5;
  localparam int WR_CYCLES    = 1;
  localparam int PULSE_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] config_addr, config_data, read_config_data;
  logic        config_read, config_write, busy;
  logic [3:0]  stall;
  logic [15:0] err_cnt;
  logic [31:0] first_err_addr, first_err_data;

  always #5 clk = ~clk;

  cgra_cfg_sequencer_if bus ();

  cgra_cfg_sequencer #(
    .NUM_COLS     (NUM_COLS),
    .RD_LAT       (RD_LAT),
    .WR_CYCLES    (WR_CYCLES),
    .PULSE_CYCLES (PULSE_CYCLES),
    .STALL_RST    (4'hF)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cmd_if           (bus.slave),
    .config_addr      (config_addr),
    .config_data      (config_data),
    .config_read      (config_read),
    .config_write     (config_write),
    .read_config_data (read_config_data),
    .stall            (stall),
    .busy             (busy),
    .err_cnt          (err_cnt),
    .first_err_addr   (first_err_addr),
    .first_err_data   (first_err_data)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Input drivers for the response side and the Interconnect read data.
  int          rsp_mode = 1;
  logic        rd_fixed = 1'b0;
  logic [31:0] rd_val = '0;
  initial begin
    bus.rsp_ready    = 1'b0;
    read_config_data = '0;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0:       bus.rsp_ready = 1'b0;
        1:       bus.rsp_ready = 1'b1;
        default: bus.rsp_ready = ($urandom_range(0, 2) != 0);
      endcase
      read_config_data = rd_fixed ? rd_val : 32'($urandom_range(0, 3));
    end
  end

  // Reference model: the last accepted command plus its accept cycle fully determine
  // every output window; values persist until a later command changes them.
  int          d_op, d_t, free_at;
  logic [31:0] d_addr, d_data;
  logic [31:0] m_addr, m_data, m_rsp_data, prev_rd;
  logic        m_rsp_valid, m_rsp_mis, m_logged, ew, er, m_ready;
  logic [3:0]  m_stall;
  logic [15:0] m_err;
  logic [31:0] m_fe_addr, m_fe_data;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      d_op = -1; d_t = 0; free_at = 0; d_addr = '0; d_data = '0;
      m_addr = '0; m_data = '0; m_rsp_data = '0; m_rsp_valid = 1'b0; m_rsp_mis = 1'b0;
      m_stall = 4'hF; m_err = '0; m_logged = 1'b0; m_fe_addr = '0; m_fe_data = '0;
    end else begin
      ew = 1'b0;
      er = 1'b0;
      case (d_op)
        0: begin
          if (cyc == d_t + 1) begin m_addr = d_addr; m_data = d_data; end
          ew = (cyc >= d_t + 1) && (cyc <= d_t + WR_CYCLES);
        end
        1, 2: begin
          if (cyc == d_t + 1) m_addr = d_addr;
          er = (cyc >= d_t + 1) && (cyc <= d_t + RD_LAT);
          if (cyc == d_t + RD_LAT + 1) begin
            m_rsp_valid = 1'b1;
            m_rsp_data  = prev_rd;
            m_rsp_mis   = (d_op == 2) && (prev_rd != d_data);
            if (m_rsp_mis) begin
              if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
`ifdef CFG_SEQ_ERR_LOG_EN
              if (!m_logged) begin m_logged = 1'b1; m_fe_addr = d_addr; m_fe_data = prev_rd; end
`endif
            end
          end
        end
        3: if (cyc == d_t + 1) m_stall = d_data[3:0];
        4: begin
          if (cyc == d_t + 1) begin m_addr = d_addr; m_data = d_data; end
          if (cyc == d_t + PULSE_CYCLES + 2) m_data = '0;
          ew = ((cyc >= d_t + 1) && (cyc <= d_t + PULSE_CYCLES)) || (cyc == d_t + PULSE_CYCLES + 2);
        end
        default: ;
      endcase
      m_ready = (cyc >= free_at) && !m_rsp_valid;
      chk("config_write", 32'(config_write), 32'(ew));
      chk("config_read", 32'(config_read), 32'(er));
      chk("config_addr", config_addr, m_addr);
      chk("config_data", config_data, m_data);
      chk("stall", 32'(stall), 32'(m_stall));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(m_ready));
      chk("busy", 32'(busy), 32'(!m_ready));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_valid));
      chk("rsp_data", bus.rsp_data, m_rsp_data);
      chk("rsp_mismatch", 32'(bus.rsp_mismatch), 32'(m_rsp_mis));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("first_err_addr", first_err_addr, m_fe_addr);
      chk("first_err_data", first_err_data, m_fe_data);
      chk("rd_wr_exclusive", 32'(config_read && config_write), 32'd0);
      if (m_rsp_valid && bus.rsp_ready) m_rsp_valid = 1'b0;
      if (bus.cmd_valid && m_ready) begin
        d_op = int'(bus.cmd_op); d_t = cyc; d_addr = bus.cmd_addr; d_data = bus.cmd_data;
        case (d_op)
          0:       free_at = cyc + WR_CYCLES + 1;
          1, 2:    free_at = cyc + RD_LAT + 1;
          4:       free_at = cyc + PULSE_CYCLES + 3;
          5:       free_at = cyc + int'(d_data) + 1;
          default: free_at = cyc + 1;
        endcase
        $display("cmd cycle=%0d op=%0d addr=%h data=%h", cyc, d_op, d_addr, d_data);
      end
    end
    prev_rd = read_config_data;
  end

  // Output activity counters over a window selected by the stimulus.
  logic mon_en = 1'b0;
  int   wr_mon = 0, busy_mon = 0, stall0_mon = 0;
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (config_write) wr_mon++;
      if (busy) busy_mon++;
      if (stall == 4'h0) stall0_mon++;
    end
  end

  task automatic send_cmd(input int op, input logic [31:0] addr, input logic [31:0] data, output int t);
    int n;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 5000);
    if (!bus.cmd_ready) chk("cmd_accept_timeout", 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_clear();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.rsp_valid && n < 200);
    if (bus.rsp_valid) chk("rsp_clear_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int t, t0, t1, tw, t2, rv;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    reset_n       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'hF);
    chk("rst_config_addr", config_addr, 32'h0);
    chk("rst_config_write", 32'(config_write), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single WRITE
    send_cmd(0, 32'h0000_0302, 32'h001C_0000, t);
    idle();
    @(negedge clk);
    chk("wr_t1_write", 32'(config_write), 32'd1);
    chk("wr_t1_addr", config_addr, 32'h0000_0302);
    chk("wr_t1_data", config_data, 32'h001C_0000);
    chk("wr_t1_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("wr_t2_write", 32'(config_write), 32'd0);
    chk("wr_t2_ready", 32'(bus.cmd_ready), 32'd1);

    // 512 back-to-back WRITEs with cmd_valid held
    wr_mon = 0;
    mon_en = 1'b1;
    t0 = 0;
    for (int i = 0; i < 512; i++) begin
      send_cmd(0, 32'h0000_0099, {8'(i), 24'h01_0201}, t);
      if (i == 0) t0 = t;
    end
    idle();
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("b2b_pulses", 32'(wr_mon), 32'd512);
    chk("b2b_span", 32'(t - t0), 32'd1022);

    // VERIFY match then mismatch
    rsp_mode = 0;
    rd_fixed = 1'b1;
    rd_val   = 32'h13;
    send_cmd(2, 32'h0000_0400, 32'h13, t);
    idle();
    repeat (5) @(negedge clk);
    chk("vfy1_t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("vfy1_t6_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("vfy1_rsp_data", bus.rsp_data, 32'h13);
    chk("vfy1_mismatch", 32'(bus.rsp_mismatch), 32'd0);
    rsp_mode = 1;
    wait_rsp_clear();
    rsp_mode = 0;
    send_cmd(2, 32'h0000_0404, 32'h14, t);
    idle();
    repeat (5) @(negedge clk);
    chk("vfy2_t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("vfy2_t6_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("vfy2_mismatch", 32'(bus.rsp_mismatch), 32'd1);
    chk("vfy2_err_cnt", 32'(err_cnt), 32'd1);
`ifdef CFG_SEQ_ERR_LOG_EN
    chk("vfy2_first_err_addr", first_err_addr, 32'h0000_0404);
    chk("vfy2_first_err_data", first_err_data, 32'h13);
`else
    chk("vfy2_first_err_addr", first_err_addr, 32'h0);
    chk("vfy2_first_err_data", first_err_data, 32'h0);
`endif
    rsp_mode = 1;
    rd_fixed = 1'b0;
    wait_rsp_clear();

    // PULSE: two high, one gap, one high with data 0
    send_cmd(4, 32'h0000_0302, 32'h001C_7E00, t);
    idle();
    @(negedge clk);
    chk("pls_t1_write", 32'(config_write), 32'd1);
    chk("pls_t1_data", config_data, 32'h001C_7E00);
    @(negedge clk);
    chk("pls_t2_write", 32'(config_write), 32'd1);
    chk("pls_t2_data", config_data, 32'h001C_7E00);
    @(negedge clk);
    chk("pls_t3_write", 32'(config_write), 32'd0);
    @(negedge clk);
    chk("pls_t4_write", 32'(config_write), 32'd1);
    chk("pls_t4_data", config_data, 32'h0);
    chk("pls_t4_addr", config_addr, 32'h0000_0302);
    @(negedge clk);
    chk("pls_t5_write", 32'(config_write), 32'd0);
    chk("pls_t5_ready", 32'(bus.cmd_ready), 32'd1);

    // STALL 0, WAIT 2000, STALL F
    busy_mon = 0;
    stall0_mon = 0;
    mon_en = 1'b1;
    send_cmd(3, 32'h0, 32'h0, t1);
    send_cmd(5, 32'h0, 32'd2000, tw);
    send_cmd(3, 32'h0, 32'hF, t2);
    idle();
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("wait_span", 32'(t2 - t1), 32'd2002);
    chk("wait_busy_cycles", 32'(busy_mon), 32'd2000);
    chk("wait_stall0_cycles", 32'(stall0_mon), 32'd2002);
    chk("wait_stall_final", 32'(stall), 32'hF);

    // Randomized command stream
    rsp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        2:       send_cmd(1, $urandom, $urandom, t);
        3:       send_cmd(2, $urandom, 32'($urandom_range(0, 3)), t);
        4:       send_cmd(3, $urandom, $urandom, t);
        5:       send_cmd(4, $urandom, $urandom, t);
        6:       send_cmd(5, $urandom, 32'($urandom_range(0, 20)), t);
        7:       send_cmd(int'($urandom_range(6, 7)), $urandom, $urandom, t);
        default: send_cmd(0, $urandom, $urandom, t);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        idle();
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end
    idle();
    rsp_mode = 1;
    repeat (40) @(negedge clk);

    // Reset asserted in the third cycle of a read with the response stalled
    rsp_mode = 0;
    send_cmd(1, 32'h0000_0500, 32'h0, t);
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rd_before_rst", 32'(config_read), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_config_read", 32'(config_read), 32'd0);
    chk("arst_config_addr", config_addr, 32'h0);
    chk("arst_config_data", config_data, 32'h0);
    chk("arst_stall", 32'(stall), 32'hF);
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_first_err_addr", first_err_addr, 32'h0);
    chk("arst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    rv = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid) rv++;
    end
    chk("post_rst_rsp_valid_cycles", 32'(rv), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
